// File: rtl/jk_pkg.sv
// Shared types for the JK command sequencer: opcodes, FSM states, opcode decode.
// Combinational helpers only; no storage.
// No flow control lives here.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_GAPW  = 2'b10
    } jk_state_t;

    // Returns {j, k} for an opcode.
    function automatic logic [1:0] op_to_jk(input jk_op_t op);
        logic [1:0] jk;
        jk = 2'b00;
        case (op)
            JK_HOLD:   jk = 2'b00;
            JK_RESET:  jk = 2'b01;
            JK_SET:    jk = 2'b10;
            JK_TOGGLE: jk = 2'b11;
            default:   jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers; async active-high reset.
// Latency: a push is visible at the head one edge later.
// Backpressure: push is dropped while full, even when a pop shares the edge.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/jk_cmd_seq.sv
// JK command sequencer: queues commands, drives registered j/k, predicts q. Optional JK_CMD_SEQ_CHECK_EN adds q_fb/mismatch.
// Latency: command pushed into an idle, empty queue drives j/k after the next edge.
// Backpressure: cmd_ready = !full; a command is held in the queue while the current one drives.
module jk_cmd_seq
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             j,
    output logic             k,
    output logic             q_exp,
    output logic             q_known,
    output logic             busy,
    output logic             done
`ifdef JK_CMD_SEQ_CHECK_EN
    ,
    input  logic             q_fb,
    output logic             mismatch
`endif
);
    localparam int GW = $clog2(GAP + 2);
    localparam logic [GW-1:0]    GAP_L   = GW'(GAP);
    localparam logic [GW-1:0]    GAP_ONE = GW'(1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    jk_state_t        state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [1:0]       jk_q, jk_d;
    logic             q_exp_q, q_exp_d;
    logic             q_known_q, q_known_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [LEN_W+1:0]   fifo_dat;
    logic               load_cmd;
    jk_op_t             head_op;
    logic [LEN_W-1:0]   head_len;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LEN_W + 2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (cmd_valid),
        .push_dat ({cmd_op, cmd_len}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign head_op  = jk_op_t'(fifo_dat[LEN_W+1:LEN_W]);
    assign head_len = fifo_dat[LEN_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            jk_q      <= 2'b00;
            q_exp_q   <= 1'b0;
            q_known_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            jk_q      <= jk_d;
            q_exp_q   <= q_exp_d;
            q_known_q <= q_known_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        jk_d     = jk_q;
        load_cmd = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_cmd = !fifo_empty;
            end
            ST_DRIVE: begin
                if (cnt_q == LEN_ONE) begin
                    if (GAP > 0) begin
                        state_d = ST_GAPW;
                        gap_d   = GAP_L;
                        jk_d    = 2'b00;
                    end else if (!fifo_empty) begin
                        load_cmd = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        jk_d    = 2'b00;
                    end
                end else begin
                    cnt_d = cnt_q - LEN_ONE;
                end
            end
            ST_GAPW: begin
                if (gap_q == GAP_ONE) begin
                    if (!fifo_empty) begin
                        load_cmd = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        jk_d    = 2'b00;
                    end
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                jk_d    = 2'b00;
            end
        endcase
        // A zero length still drives for one cycle.
        if (load_cmd) begin
            fifo_pop = 1'b1;
            state_d  = ST_DRIVE;
            cnt_d    = (head_len == '0) ? LEN_ONE : head_len;
            jk_d     = op_to_jk(head_op);
        end
    end

    // Mirrors the flip-flop sampling the same registered j/k on the same edge.
    always_comb begin
        q_exp_d = q_exp_q;
        case (jk_q)
            2'b01:   q_exp_d = 1'b0;
            2'b10:   q_exp_d = 1'b1;
            2'b11:   q_exp_d = ~q_exp_q;
            default: q_exp_d = q_exp_q;
        endcase
        q_known_d = q_known_q | (jk_q[1] ^ jk_q[0]);
    end

    always_comb begin
        j         = jk_q[1];
        k         = jk_q[0];
        q_exp     = q_exp_q;
        q_known   = q_known_q;
        cmd_ready = !fifo_full;
        busy      = (state_q != ST_IDLE) || !fifo_empty;
        done      = (state_q == ST_DRIVE) && (cnt_q == LEN_ONE);
    end

`ifdef JK_CMD_SEQ_CHECK_EN
    logic mismatch_q, mismatch_d;

    always_comb begin
        mismatch_d = mismatch_q | (q_known_q && (q_fb != q_exp_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Directed bench for jk_cmd_seq: one GAP=1 and one GAP=0 instance share stimulus.
// Observed bit order: {j, k, done, q_exp, q_known, busy, cmd_ready}.
module tb_jk_cmd_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_len = 4'd0;
    logic       sel = 1'b0;

    logic j_g1, k_g1, q_g1, kn_g1, busy_g1, done_g1, rdy_g1;
    logic j_g0, k_g0, q_g0, kn_g0, busy_g0, done_g0, rdy_g0;
    logic [6:0] obs;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

`ifdef JK_CMD_SEQ_CHECK_EN
    logic q_m = 1'b0;
    logic inv = 1'b0;
    logic q_fb_g1, q_fb_g0, mm_g1, mm_g0;
    always @(posedge clk or posedge rst) begin
        if (rst) q_m <= 1'b0;
        else case ({j_g1, k_g1})
            2'b01:   q_m <= 1'b0;
            2'b10:   q_m <= 1'b1;
            2'b11:   q_m <= ~q_m;
            default: q_m <= q_m;
        endcase
    end
    assign q_fb_g1 = q_m ^ inv;
    assign q_fb_g0 = q_g0;
`endif

    jk_cmd_seq #(.DEPTH(4), .LEN_W(4), .GAP(1)) u_g1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy_g1),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j_g1), .k(k_g1),
        .q_exp(q_g1), .q_known(kn_g1), .busy(busy_g1), .done(done_g1)
`ifdef JK_CMD_SEQ_CHECK_EN
        , .q_fb(q_fb_g1), .mismatch(mm_g1)
`endif
    );

    jk_cmd_seq #(.DEPTH(4), .LEN_W(4), .GAP(0)) u_g0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy_g0),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j_g0), .k(k_g0),
        .q_exp(q_g0), .q_known(kn_g0), .busy(busy_g0), .done(done_g0)
`ifdef JK_CMD_SEQ_CHECK_EN
        , .q_fb(q_fb_g0), .mismatch(mm_g0)
`endif
    );

    assign obs = sel ? {j_g0, k_g0, done_g0, q_g0, kn_g0, busy_g0, rdy_g0}
                     : {j_g1, k_g1, done_g1, q_g1, kn_g1, busy_g1, rdy_g1};

    typedef struct {
        logic       vld;
        logic [1:0] op;
        logic [3:0] len;
        logic [6:0] exp;
    } vec_t;

    vec_t tab_a[26];
    vec_t tab_b[6];

    function automatic vec_t mk(input logic vld, input logic [1:0] op,
                                input logic [3:0] len, input logic [6:0] exp);
        vec_t v;
        v.vld = vld; v.op = op; v.len = len; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string name, input int idx, input vec_t v);
        cmd_valid = v.vld;
        cmd_op    = v.op;
        cmd_len   = v.len;
        @(posedge clk);
        #1;
        check($sformatf("%s[%0d] {j,k,done,q,known,busy,rdy}", name, idx), int'(obs), int'(v.exp));
    endtask

    initial begin
        int pushes, pop_k, push_k, waited;
        logic acc;

        // GAP=1: SET2, RESET3, then toggle parity runs (TOGGLE 3, TOGGLE 4).
        tab_a[0]  = mk(1, 2'b10, 4'd2, 7'b0000011);
        tab_a[1]  = mk(1, 2'b01, 4'd3, 7'b1000011);
        tab_a[2]  = mk(0, 2'b00, 4'd0, 7'b1011111);
        tab_a[3]  = mk(0, 2'b00, 4'd0, 7'b0001111);
        tab_a[4]  = mk(0, 2'b00, 4'd0, 7'b0101111);
        tab_a[5]  = mk(0, 2'b00, 4'd0, 7'b0100111);
        tab_a[6]  = mk(0, 2'b00, 4'd0, 7'b0110111);
        tab_a[7]  = mk(0, 2'b00, 4'd0, 7'b0000111);
        tab_a[8]  = mk(0, 2'b00, 4'd0, 7'b0000101);
        tab_a[9]  = mk(1, 2'b10, 4'd1, 7'b0000111);
        tab_a[10] = mk(1, 2'b11, 4'd3, 7'b1010111);
        tab_a[11] = mk(0, 2'b00, 4'd0, 7'b0001111);
        tab_a[12] = mk(0, 2'b00, 4'd0, 7'b1101111);
        tab_a[13] = mk(0, 2'b00, 4'd0, 7'b1100111);
        tab_a[14] = mk(0, 2'b00, 4'd0, 7'b1111111);
        tab_a[15] = mk(0, 2'b00, 4'd0, 7'b0000111);
        tab_a[16] = mk(0, 2'b00, 4'd0, 7'b0000101);
        tab_a[17] = mk(1, 2'b10, 4'd1, 7'b0000111);
        tab_a[18] = mk(1, 2'b11, 4'd4, 7'b1010111);
        tab_a[19] = mk(0, 2'b00, 4'd0, 7'b0001111);
        tab_a[20] = mk(0, 2'b00, 4'd0, 7'b1101111);
        tab_a[21] = mk(0, 2'b00, 4'd0, 7'b1100111);
        tab_a[22] = mk(0, 2'b00, 4'd0, 7'b1101111);
        tab_a[23] = mk(0, 2'b00, 4'd0, 7'b1110111);
        tab_a[24] = mk(0, 2'b00, 4'd0, 7'b0001111);
        tab_a[25] = mk(0, 2'b00, 4'd0, 7'b0001101);
        // GAP=0: SET1, RESET1, TOGGLE0 back-to-back.
        tab_b[0]  = mk(1, 2'b10, 4'd1, 7'b0000011);
        tab_b[1]  = mk(1, 2'b01, 4'd1, 7'b1010011);
        tab_b[2]  = mk(1, 2'b11, 4'd0, 7'b0111111);
        tab_b[3]  = mk(0, 2'b00, 4'd0, 7'b1110111);
        tab_b[4]  = mk(0, 2'b00, 4'd0, 7'b0001101);
        tab_b[5]  = mk(0, 2'b00, 4'd0, 7'b0001101);

        repeat (2) @(posedge clk);
        #1;
        sel = 1'b0; #1 check("reset_g1", int'(obs), 7'b0000001);
        sel = 1'b1; #1 check("reset_g0", int'(obs), 7'b0000001);
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 26; i++) run_vec("gap1", i, tab_a[i]);

        // Backpressure: HOLD len 15 stalls the FSM while SETs queue up.
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_len = 4'd15;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd1;
        pushes = 0; pop_k = 0; push_k = 0;
        for (int kk = 1; kk <= 40; kk++) begin
            acc = cmd_valid && rdy_g1;
            @(posedge clk); #1;
            if (acc) pushes++;
            if (j_g1 && pop_k == 0) pop_k = kk;
            if (kk == 12) begin
                check("full_push_count", pushes, 4);
                check("full_ready_low", int'(rdy_g1), 0);
            end
            if (pushes == 5) begin
                push_k = kk;
                cmd_valid = 1'b0;
                break;
            end
        end
        check("first_pop_edge", pop_k, 16);
        check("fifth_push_edge", push_k, 17);
        waited = 0;
        while (busy_g1 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("drain_idle_busy", int'(busy_g1), 0);

        // Reset mid-DRIVE with two commands still queued.
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd5;
        @(posedge clk); #1;
        cmd_op = 2'b01; cmd_len = 4'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_j", int'(j_g1), 1);
        #1 rst = 1'b1;
        #1 check("async_reset", int'(obs), 7'b0000001);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("queue_abandoned", int'(obs), 7'b0000001);

        sel = 1'b1;
        for (int i = 0; i < 6; i++) run_vec("gap0", i, tab_b[i]);
        sel = 1'b0;

`ifdef JK_CMD_SEQ_CHECK_EN
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("mismatch_clean", int'(mm_g1), 0);
        @(negedge clk); inv = 1'b1;
        @(negedge clk); inv = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("mismatch_sticky", int'(mm_g1), 1);
        rst = 1'b1;
        #1 check("mismatch_reset", int'(mm_g1), 0);
        @(negedge clk); rst = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
